// File: rtl/scanning_channel_mux.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan modes.
// Scan mode steps through the enabled channels, spending DWELL cycles on each, and pulses wrap when the index wraps.
module scanning_channel_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       en_mask,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    STALL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             adv;
  logic [SEL_W-1:0] nxt;

  // Lowest enabled index strictly above 'from'; if none, the lowest enabled index overall.
  function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] from,
                                               input logic [CHANNELS-1:0] mask);
    logic             found_hi, found_lo;
    logic [SEL_W-1:0] hi, lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi       = '0;
    lo       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mask[k] && !found_lo) begin
        lo       = SEL_W'(k);
        found_lo = 1'b1;
      end
      if (mask[k] && !found_hi && (SEL_W'(k) > from)) begin
        hi       = SEL_W'(k);
        found_hi = 1'b1;
      end
    end
    return found_hi ? hi : lo;
  endfunction

  function automatic logic is_enabled(input logic [SEL_W-1:0] idx,
                                      input logic [CHANNELS-1:0] mask);
    logic r;
    r = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == SEL_W'(k)) r = mask[k];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] slice(input logic [CHANNELS*WIDTH-1:0] data,
                                             input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == SEL_W'(k)) r = data[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    y_d     = y_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    adv     = 1'b0;
    nxt     = ch_q;

    if (!hold) begin
      cnt_d = '0;
      if (!mode) begin
        state_d = MANUAL;
        nxt     = sel;
      end else if (en_mask == '0) begin
        state_d = STALL;
      end else begin
        state_d = SCAN;
        case (state_q)
          SCAN: begin
            if (!is_enabled(ch_q, en_mask) || (cnt_q == CNT_LAST)) adv = 1'b1;
            else cnt_d = cnt_q + 1'b1;
          end
          STALL:   adv = 1'b1;
          // Entering from MANUAL: stay on the current channel if it is enabled.
          default: adv = !is_enabled(ch_q, en_mask);
        endcase
        if (adv) nxt = next_en(ch_q, en_mask);
      end

      ch_d    = nxt;
      wrap_d  = adv && (nxt <= ch_q);
      valid_d = (state_d != STALL) && (int'(nxt) < CHANNELS);
      y_d     = valid_d ? slice(din, nxt) : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      ch_q    <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/scanning_channel_mux.md
Name: scanning_channel_mux

Overview:
- Registered, parametrised N-channel, W-bit multiplexer; the next generation of the lab's combinational 8:1 x 4-bit mux.
- Adds two selection modes:
  - manual select, with one-cycle registered latency;
  - auto-scan, which steps through enabled channels with a programmable dwell time.
- Adds a hold/freeze control, a valid flag and a scan-wrap pulse.
- Sits between the input channel bank (switches/sensors) and display or downstream logic.

Parameters:
- WIDTH, 4, bits per channel (>=1).
- CHANNELS, 8, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), selector/index width (derived; do not override).
- DWELL, 4, clock cycles spent on each channel in scan mode (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  CHANNELS*WIDTH  flattened channel inputs; channel k occupies din[k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select in manual mode.
- mode  input  1  0 = manual, 1 = auto-scan.
- en_mask  input  CHANNELS  per-channel enable for scan mode (bit k = channel k); ignored in manual mode.
- hold  input  1  freezes all state and outputs while high.
- y  output  WIDTH  registered selected data.
- ch  output  SEL_W  index of the channel currently presented on y.
- valid  output  1  y holds legal channel data.
- wrap  output  1  one-cycle pulse when the scan index wraps from a higher index to a lower-or-equal one.

Behaviour:
- Reset (async, rst_n=0):
  - y=0, ch=0, valid=0, wrap=0;
  - dwell counter cnt=0; FSM=MANUAL.
  - Takes effect immediately, mid-operation included.
- Registered datapath. At every rising edge with hold=0, compute next index nxt and register:
  - ch<=nxt;
  - y<=din slice nxt, sampled at that same edge.
  - y and ch are therefore always coherent. Latency from din or sel to y is 1 cycle.
- hold=1 has priority over everything except reset: y, ch, valid, cnt and FSM keep their values; wrap=0.
- FSM states: MANUAL, SCAN, STALL.
- MANUAL (mode=0):
  - nxt=sel, cnt<=0.
  - If sel>=CHANNELS (non-power-of-two CHANNELS only): y<=0, valid<=0, ch<=sel.
  - Otherwise valid<=1.
  - en_mask is ignored.
- MANUAL -> SCAN when mode=1:
  - if en_mask has any bit set, the first SCAN cycle starts from the current ch with cnt<=0;
  - if ch is disabled, nxt = next enabled index above ch (circular).
- SCAN:
  - cnt increments every cycle.
  - When cnt==DWELL-1: nxt = next enabled index after ch, ascending and circular; cnt<=0.
  - If the current ch becomes disabled mid-dwell: advance to the next enabled channel at the next edge and reset cnt<=0.
  - A single enabled channel means the index stays on it; wrap pulses every DWELL cycles (index wraps onto itself).
  - valid<=1.
- wrap: asserted for one cycle, registered together with ch, whenever an advance yields nxt<=ch.
- Any state -> STALL when mode=1 and en_mask==0:
  - y<=0, valid<=0, ch holds, cnt<=0.
  - STALL -> SCAN once en_mask!=0: nxt = first enabled index after ch (circular), cnt<=0.
- SCAN or STALL -> MANUAL when mode=0, effective on that same edge (nxt=sel).
- Simultaneous events:
  - hold masks mode changes and en_mask changes until hold falls; then they are evaluated normally.
  - A mode change at the dwell boundary: the mode change wins.
- DWELL=1: the index advances every cycle.

Test Plan:
- Reset/manual: assert rst_n=0 mid-cycle -> y=0, ch=0, valid=0 immediately. Release; mode=0, sel=5, din ch5=4'hA -> next edge y=4'hA, ch=5, valid=1.
- Manual latency: change ch3 data 4'h3 -> 4'hC while sel=3 -> y updates exactly one edge later. Change sel 3 -> 6 -> ch=6 and y=ch6 data one edge later.
- Scan dwell/wrap: DWELL=4, en_mask=8'b1000_0101, start ch=0.
  - ch sequence 0,0,0,0,2,2,2,2,7,7,7,7,0.
  - wrap=1 only on the cycle ch returns to 0.
- Mask change mid-dwell: scanning on ch2, clear en_mask bit 2 at cnt=1 -> next edge ch=7, cnt=0. Then en_mask=0 -> STALL: valid=0, y=0, ch=7. Set bit 4 -> ch=4, valid=1.
- Hold: hold=1 for 10 cycles during SCAN while toggling din and mode -> y, ch, valid frozen, wrap=0. Release -> scan resumes from the saved cnt value.
- Parameter sweep: CHANNELS=5, WIDTH=8, DWELL=1 -> scan visits 0..4 every cycle. Manual sel=6 -> valid=0, y=0.
